// File: rtl/zx_video_pkg.sv
// Shared definitions for the ZX Spectrum video path: paper offsets, attribute
// base, pixel bit layout and the attribute byte layout.
package zx_video_pkg;

    localparam int unsigned H_OFF_DEF = 64;
    localparam int unsigned V_OFF_DEF = 48;

    localparam logic [12:0] ATTR_BASE = 13'h1800;

    // pix = {bright, G, R, B}
    localparam int unsigned PIX_BRIGHT = 3;
    localparam int unsigned PIX_G      = 2;
    localparam int unsigned PIX_R      = 1;
    localparam int unsigned PIX_B      = 0;

    typedef enum logic {
        SelBitmap = 1'b0,
        SelAttr   = 1'b1
    } addr_sel_e;

    typedef struct packed {
        logic       flash;
        logic       bright;
        logic [2:0] paper;
        logic [2:0] ink;
    } attr_t;

endpackage

// File: rtl/zx_screen_fetch_if.sv
// Frame-buffer read port: byte address out, byte data back after a fixed latency.
interface zx_screen_fetch_if;

    logic [12:0] video_addr;
    logic [7:0]  video_data;

    modport master (output video_addr, input video_data);
    modport slave  (input video_addr, output video_data);

endinterface

// File: rtl/zx_scr_addr.sv
// Combinational ZX screen address: bitmap bytes use the interleaved third/row/line
// layout, attribute bytes are linear from ATTR_BASE.
module zx_scr_addr
    import zx_video_pkg::*;
(
    input  logic [7:0]  sy,
    input  logic [4:0]  c,
    input  addr_sel_e   sel,
    output logic [12:0] addr
);

    // Select bitmap or attribute address for screen line sy, cell column c.
    always_comb begin
        if (sel == SelAttr) begin
            addr = ATTR_BASE + {3'b000, sy[7:3], c};
        end else begin
            addr = {sy[7:6], sy[2:0], sy[5:3], c};
        end
    end

endmodule

// File: rtl/zx_screen_fetch.sv
// Pixel-fetch stage: reads bitmap/attribute bytes one cell ahead of the beam,
// shifts out pixel bits, applies attribute/flash rules and border, and delays
// de/hs/vs by one clock to line up with pix. MEM_LAT must lie in 1..12.
module zx_screen_fetch
    import zx_video_pkg::*;
#(
    parameter int unsigned H_OFF   = H_OFF_DEF,
    parameter int unsigned V_OFF   = V_OFF_DEF,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              de_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [2:0]        border,
    zx_screen_fetch_if.master mem,
    output logic [3:0]        pix,
    output logic              de_out,
    output logic              hs_out,
    output logic              vs_out
);

    localparam logic [9:0] PAPER_X0 = 10'(H_OFF);
    localparam logic [9:0] PAPER_X1 = 10'(H_OFF + 512);
    localparam logic [9:0] PAPER_Y0 = 10'(V_OFF);
    localparam logic [9:0] PAPER_Y1 = 10'(V_OFF + 384);
    localparam logic [9:0] FETCH_X0 = 10'(H_OFF - 16);
    localparam logic [9:0] FETCH_X1 = 10'(H_OFF + 496);
    localparam logic [3:0] P_BMP    = 4'(MEM_LAT);
    localparam logic [3:0] P_ATTR   = 4'(MEM_LAT + 1);

    logic        paper_line;
    logic        in_win;
    logic        nin_win;
    logic        in_paper;
    logic [9:0]  dy;
    logic [9:0]  dx;
    logic [9:0]  fx;
    logic [9:0]  nx;
    logic [9:0]  nfx;
    logic [7:0]  sy;
    logic [2:0]  sx_lo;
    logic [3:0]  phase;
    logic [3:0]  nphase;
    logic [4:0]  ncell;
    addr_sel_e   nsel;
    logic [12:0] fetch_addr;

    logic [12:0] video_addr_q;
    logic [7:0]  next_bmp_q;
    logic [7:0]  shifter_q;
    attr_t       next_attr_q;
    attr_t       cur_attr_q;
    logic [4:0]  flash_cnt_q;
    logic [3:0]  pix_d;
    logic [3:0]  pix_q;
    logic        de_q;
    logic        hs_q;
    logic        vs_q;

    logic [2:0]  ink;
    logic [2:0]  paper;
    logic        pix_bit;
    logic        unused_bits;

    // Beam position decode for the current pixel and for the next one (address lookahead).
    always_comb begin
        paper_line = (y >= PAPER_Y0) && (y < PAPER_Y1);
        dy         = y - PAPER_Y0;
        sy         = dy[8:1];
        fx         = x - FETCH_X0;
        phase      = fx[3:0];
        in_win     = paper_line && (x >= FETCH_X0) && (x < FETCH_X1);
        nx         = x + 10'd1;
        nfx        = nx - FETCH_X0;
        nphase     = nfx[3:0];
        ncell      = nfx[8:4];
        nin_win    = paper_line && (nx >= FETCH_X0) && (nx < FETCH_X1);
        nsel       = (nphase == 4'd1) ? SelAttr : SelBitmap;
        dx         = x - PAPER_X0;
        sx_lo      = dx[3:1];
        in_paper   = paper_line && (x >= PAPER_X0) && (x < PAPER_X1);
    end

    assign unused_bits = ^{dy[9], dy[0], fx[9:4], nfx[9], dx[9:4], dx[0]};

    zx_scr_addr u_scr_addr (
        .sy   (sy),
        .c    (ncell),
        .sel  (nsel),
        .addr (fetch_addr)
    );

    // Address is registered from the lookahead so it is stable for the whole of
    // phases 0 and 1; data latches and the end-of-cell load follow the current phase.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            video_addr_q <= '0;
            next_bmp_q   <= '0;
            next_attr_q  <= '0;
            shifter_q    <= '0;
            cur_attr_q   <= '0;
        end else begin
            if (nin_win && (nphase <= 4'd1)) begin
                video_addr_q <= fetch_addr;
            end
            if (in_win && (phase == P_BMP)) begin
                next_bmp_q <= mem.video_data;
            end
            if (in_win && (phase == P_ATTR)) begin
                next_attr_q <= attr_t'(mem.video_data);
            end
            if (in_win && (phase == 4'd15)) begin
                shifter_q  <= next_bmp_q;
                cur_attr_q <= next_attr_q;
            end
        end
    end

    // Frame counter: counts vs_in falling edges against the registered vs copy.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            flash_cnt_q <= '0;
        end else if (vs_q && !vs_in) begin
            flash_cnt_q <= flash_cnt_q + 5'd1;
        end
    end

    // Colour select for the current pixel: paper/ink from the shifter, else border or black.
    always_comb begin
        ink   = cur_attr_q.ink;
        paper = cur_attr_q.paper;
        if (cur_attr_q.flash && flash_cnt_q[4]) begin
            ink   = cur_attr_q.paper;
            paper = cur_attr_q.ink;
        end
        pix_bit = shifter_q[3'd7 - sx_lo];
        pix_d   = 4'h0;
        if (in_paper) begin
            pix_d[PIX_BRIGHT]  = cur_attr_q.bright;
            pix_d[PIX_G:PIX_B] = pix_bit ? ink : paper;
        end else if (de_in) begin
            pix_d[PIX_G:PIX_B] = border;
        end
    end

    // Output register: pix and syncs share the same single-cycle latency.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            pix_q <= 4'h0;
            de_q  <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            pix_q <= pix_d;
            de_q  <= de_in;
            hs_q  <= hs_in;
            vs_q  <= vs_in;
        end
    end

    assign mem.video_addr = video_addr_q;
    assign pix            = pix_q;
    assign de_out         = de_q;
    assign hs_out         = hs_q;
    assign vs_out         = vs_q;

endmodule

// File: tb/tb_zx_screen_fetch.sv
// Scoreboard bench: three DUTs (MEM_LAT 1, 2, 12) share one frame buffer model.
// The driver pushes expected outputs per cycle; the monitor pops and compares.
module tb_zx_screen_fetch;

    logic       clk = 1'b0;
    logic       nRESET;
    logic [9:0] x;
    logic [9:0] y;
    logic       de_in;
    logic       hs_in;
    logic       vs_in;
    logic [2:0] border;

    logic [3:0] pix1, pix2, pix12;
    logic       de1, hs1, vs1, de2, hs2, vs2, de12, hs12, vs12;

    zx_screen_fetch_if if1 ();
    zx_screen_fetch_if if2 ();
    zx_screen_fetch_if if12 ();

    logic [7:0]  mem [0:8191];
    logic [12:0] h1  [0:0];
    logic [12:0] h2  [0:1];
    logic [12:0] h12 [0:11];

    typedef struct {
        int         stamp;
        logic [3:0] pix;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    typedef struct {
        int          stamp;
        logic [12:0] addr;
    } aexp_t;

    exp_t  q[$];
    aexp_t aq[$];

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic       done   = 1'b0;
    logic [4:0] fcnt   = 5'd0;
    logic       prev_vs = 1'b1;

    logic [63:0] a5pat = 64'hFF88_FF88_88FF_88FF;
    int          tbl_y   [4];
    logic [12:0] tbl_b0  [4];
    logic [12:0] tbl_a0  [4];
    logic [12:0] tbl_b31 [4];
    logic [12:0] tbl_a31 [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    zx_screen_fetch #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .nRESET(nRESET), .x(x), .y(y), .de_in(de_in), .hs_in(hs_in),
        .vs_in(vs_in), .border(border), .mem(if1), .pix(pix1), .de_out(de1),
        .hs_out(hs1), .vs_out(vs1)
    );

    zx_screen_fetch #(.MEM_LAT(2)) u_dut2 (
        .clk(clk), .nRESET(nRESET), .x(x), .y(y), .de_in(de_in), .hs_in(hs_in),
        .vs_in(vs_in), .border(border), .mem(if2), .pix(pix2), .de_out(de2),
        .hs_out(hs2), .vs_out(vs2)
    );

    zx_screen_fetch #(.MEM_LAT(12)) u_dut12 (
        .clk(clk), .nRESET(nRESET), .x(x), .y(y), .de_in(de_in), .hs_in(hs_in),
        .vs_in(vs_in), .border(border), .mem(if12), .pix(pix12), .de_out(de12),
        .hs_out(hs12), .vs_out(vs12)
    );

    // Memory latency model: data for the address seen in cycle k appears in cycle k+LAT.
    always @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            h1[0] <= '0;
            h2[0] <= '0;
            h2[1] <= '0;
            for (int i = 0; i < 12; i++) h12[i] <= '0;
        end else begin
            h1[0]  <= if1.video_addr;
            h2[0]  <= if2.video_addr;
            h2[1]  <= h2[0];
            h12[0] <= if12.video_addr;
            for (int i = 1; i < 12; i++) h12[i] <= h12[i-1];
        end
    end

    assign if1.video_data  = mem[h1[0]];
    assign if2.video_data  = mem[h2[1]];
    assign if12.video_data = mem[h12[11]];

    // Reference screen: what the pixel at (px, py) should look like.
    function automatic logic [3:0] model_pix(input logic [9:0] px, input logic [9:0] py,
                                             input logic pde, input logic [2:0] pb,
                                             input logic pflash);
        logic [9:0]  dx, dy;
        logic [7:0]  sx, sy, b, a;
        logic [2:0]  ink, pap;
        logic [12:0] ba, aa;
        if (px >= 10'd64 && px < 10'd576 && py >= 10'd48 && py < 10'd432) begin
            dx  = px - 10'd64;
            dy  = py - 10'd48;
            sx  = dx[8:1];
            sy  = dy[8:1];
            ba  = {sy[7:6], sy[2:0], sy[5:3], sx[7:3]};
            aa  = 13'h1800 + {3'b000, sy[7:3], sx[7:3]};
            b   = mem[ba];
            a   = mem[aa];
            ink = a[2:0];
            pap = a[5:3];
            if (a[7] && pflash) begin
                ink = a[5:3];
                pap = a[2:0];
            end
            return {a[6], b[3'd7 - sx[2:0]] ? ink : pap};
        end else if (pde) begin
            return {1'b0, pb};
        end
        return 4'h0;
    endfunction

    task automatic step(input logic prst, input logic [9:0] px, input logic [9:0] py,
                        input logic pde, input logic phs, input logic pvs,
                        input logic [2:0] pb, input logic hh, input logic [3:0] hv);
        exp_t e;
        @(posedge clk);
        #1;
        nRESET = prst;
        x      = px;
        y      = py;
        de_in  = pde;
        hs_in  = phs;
        vs_in  = pvs;
        border = pb;
        e.stamp = cyc;
        if (!prst) begin
            e.pix = 4'h0;
            e.de  = 1'b0;
            e.hs  = 1'b1;
            e.vs  = 1'b1;
        end else begin
            e.pix = hh ? hv : model_pix(px, py, pde, pb, fcnt[4]);
            e.de  = pde;
            e.hs  = phs;
            e.vs  = pvs;
            if (prev_vs && !pvs) fcnt = fcnt + 5'd1;
            prev_vs = pvs;
        end
        q.push_back(e);
    endtask

    task automatic push_addr(input logic [12:0] a);
        aexp_t ae;
        ae.stamp = cyc;
        ae.addr  = a;
        aq.push_back(ae);
    endtask

    // One line: x 0..659, visible below 640, hs low 648..655. hand_mode pins the
    // first paper cell to a hand-computed pattern (1: A5/47, 2: all 7, 3: all 0).
    task automatic run_line(input logic [9:0] py, input int hand_mode, input int rst_until,
                            input logic [2:0] b_first, input logic [2:0] b_second);
        for (int i = 0; i < 660; i++) begin
            logic       hh;
            logic [3:0] hv;
            hh = 1'b0;
            hv = 4'h0;
            if (hand_mode != 0 && i >= 64 && i < 80) begin
                hh = 1'b1;
                case (hand_mode)
                    1:       hv = a5pat[4*(15-(i-64)) +: 4];
                    2:       hv = 4'h7;
                    default: hv = 4'h0;
                endcase
            end
            step((i >= rst_until), 10'(i), py, (i < 640), !(i >= 648 && i < 656), 1'b1,
                 (i < 300) ? b_first : b_second, hh, hv);
            if (rst_until > 0) begin
                if ((i % 50) == 0 || i == 620) push_addr(13'h0000);
            end else begin
                for (int t = 0; t < 4; t++) begin
                    if (int'(py) == tbl_y[t]) begin
                        if (i == 48)  push_addr(tbl_b0[t]);
                        if (i == 49)  push_addr(tbl_a0[t]);
                        if (i == 544) push_addr(tbl_b31[t]);
                        if (i == 545) push_addr(tbl_a31[t]);
                        if (i == 600) push_addr(tbl_a31[t]);
                    end
                end
            end
        end
    endtask

    task automatic vs_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, 10'd700, 10'd500, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h0);
            step(1'b1, 10'd700, 10'd500, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h0);
            step(1'b1, 10'd700, 10'd500, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 4'h0);
            step(1'b1, 10'd700, 10'd500, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 4'h0);
        end
    endtask

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", name, cyc, got, want);
        end
    endtask

    // Monitor: compare whatever the scoreboard expects for this cycle.
    always @(negedge clk) begin
        aexp_t ae;
        exp_t  e;
        if (aq.size() > 0 && aq[0].stamp == cyc) begin
            ae = aq.pop_front();
            chk("video_addr", if2.video_addr, ae.addr);
        end
        if (q.size() > 0 && q[0].stamp + 1 == cyc) begin
            e = q.pop_front();
            chk("pix_lat1", 13'(pix1), 13'(e.pix));
            chk("pix_lat2", 13'(pix2), 13'(e.pix));
            chk("pix_lat12", 13'(pix12), 13'(e.pix));
            chk("sync_lat2", 13'({de2, hs2, vs2}), 13'({e.de, e.hs, e.vs}));
            chk("sync_lat1_12", 13'({de1, hs1, vs1, de12, hs12, vs12}),
                13'({e.de, e.hs, e.vs, e.de, e.hs, e.vs}));
        end
        if (done) begin
            checks++;
            if (q.size() != 0 || aq.size() != 0) begin
                errors++;
                $display("FAIL drain pending %0d want 0", q.size() + aq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout reached want finish");
        $fatal(1);
    end

    initial begin
        tbl_y   = '{48, 50, 64, 430};
        tbl_b0  = '{13'h0000, 13'h0100, 13'h0020, 13'h17E0};
        tbl_a0  = '{13'h1800, 13'h1800, 13'h1820, 13'h1AE0};
        tbl_b31 = '{13'h001F, 13'h011F, 13'h003F, 13'h17FF};
        tbl_a31 = '{13'h181F, 13'h181F, 13'h183F, 13'h1AFF};

        nRESET = 1'b0;
        x      = 10'd0;
        y      = 10'd48;
        de_in  = 1'b0;
        hs_in  = 1'b1;
        vs_in  = 1'b1;
        border = 3'b000;

        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[13'h0000] = 8'hA5;
        mem[13'h1800] = 8'h47;

        // Reset held through most of a paper line, released in the border.
        run_line(10'd48, 0, 600, 3'b010, 3'b010);
        // Border line with a mid-line border change.
        run_line(10'd47, 0, 0, 3'b010, 3'b101);
        // Pixel pattern and address order.
        run_line(10'd48, 1, 0, 3'b010, 3'b010);
        run_line(10'd50, 0, 0, 3'b001, 3'b001);
        run_line(10'd64, 0, 0, 3'b110, 3'b110);
        run_line(10'd430, 0, 0, 3'b011, 3'b011);

        // Flash: ink 7 / paper 0 with flash attribute over a solid bitmap byte.
        mem[13'h0000] = 8'hFF;
        mem[13'h1800] = 8'h87;
        run_line(10'd48, 2, 0, 3'b000, 3'b000);
        vs_pulses(16);
        run_line(10'd48, 3, 0, 3'b000, 3'b000);
        vs_pulses(16);
        run_line(10'd48, 2, 0, 3'b000, 3'b000);

        // Random frame buffer across all latencies.
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        run_line(10'd100, 0, 0, 3'b100, 3'b100);
        run_line(10'd201, 0, 0, 3'b111, 3'b111);
        run_line(10'd300, 0, 0, 3'b001, 3'b010);
        run_line(10'd431, 0, 0, 3'b101, 3'b101);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 10'd700, 10'd500, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 4'h0);
        end
        repeat (3) @(posedge clk);
        done = 1'b1;
    end

endmodule

// File: doc/zx_screen_fetch.md
# zx_screen_fetch

Pixel-fetch stage between the VGA timing generator and memory port B of the 128k RAM. For each VGA pixel it produces the ZX Spectrum screen colour:
- 256×192 bitmap, each pixel doubled to 512×384, centred in 640×480;
- border elsewhere.

It issues bitmap and attribute reads on the frame-buffer port one character cell ahead, applies attribute/flash rules, and re-times sync and blank to its output latency.

## Interface
- H_OFF, 64: first active VGA column of the paper area
- V_OFF, 48: first active VGA line of the paper area
- MEM_LAT, 2: clk cycles from video_addr change to valid video_data; legal range 1..12
- clk  in  1  pixel clock (clock_25)
- nRESET  in  1  reset, asynchronous, active-low
- x  in  10  current VGA column, 0..799
- y  in  10  current VGA line, 0..524
- de_in  in  1  visible-area flag aligned with x/y
- hs_in, vs_in  in  1  syncs aligned with x/y
- border  in  3  border colour {G,R,B}
- video_addr  out  13  frame-buffer byte address; 0000–17FF bitmap, 1800–1AFF attributes
- video_data  in  8  frame-buffer byte, valid MEM_LAT cycles after video_addr
- pix  out  4  colour {bright,G,R,B}
- de_out, hs_out, vs_out  out  1  de_in/hs_in/vs_in delayed to match pix

## Operation
- Reset values: pix=0, de_out=0, hs_out=1, vs_out=1, video_addr=0, flash counter=0, shifter/attr regs=0.
- Paper area: x in [H_OFF, H_OFF+512) and y in [V_OFF, V_OFF+384).
- Screen coordinates: sx=(x−H_OFF)>>1 (0..255), sy=(y−V_OFF)>>1 (0..191). A cell spans 16 VGA columns.
- Fetch window:
  - For a paper line, fetches for cell c run at x = H_OFF−16+16c, c=0..31.
  - Phase p=(x−H_OFF+16)&15.
  - p=0: video_addr = {sy[7:6], sy[2:0], sy[5:3], c[4:0]} (bitmap).
  - p=1: video_addr = 13'h1800 + {sy[7:3], c[4:0]} (attribute).
  - p=MEM_LAT: latch video_data into next_bmp.
  - p=1+MEM_LAT: latch video_data into next_attr.
  - p=15: load shifter←next_bmp, cur_attr←next_attr.
  - Outside the window, video_addr holds its last value.
- Colour select:
  - bit = shifter[7−((x−H_OFF)>>1 & 7)].
  - ink = attr[2:0], paper = attr[5:3], bright = attr[6].
  - If attr[7] and flash=1, swap ink and paper.
  - pix = {bright, bit ? ink : paper}.
- Border region, de_in=1: pix = {0, border}. de_in=0: pix = 0.
- Flash:
  - 5-bit frame counter increments on each vs_in falling edge (detected against a registered copy).
  - flash = counter[4], toggling every 16 frames; wraps 31→0.
- Border changes take effect on the next pixel; no mid-cell latching.

## Timing
- Output latency: pix, de_out, hs_out, vs_out are registered exactly 1 clk after the x/y/de_in/hs_in/vs_in they correspond to.
- The read sequence completes by p=1+MEM_LAT ≤ 13 < 15, so data is always ready before the p=15 load.
- Back-to-back cells: the p=15 load of cell c and the p=0 address of cell c+1 occur in consecutive cycles with no bubble.
- Lines outside the paper area issue no fetches. The last fetch of a line is for cell 31; no fetch is issued for a cell 32.
- Edge cases:
  - x wrap 799→0 mid-line never occurs inside the fetch window.
  - y=V_OFF+383 is the last fetching line.
- nRESET asserted mid-frame: all state clears immediately. After release, the first correct paper pixels appear on the next paper line whose fetch window starts after release. Earlier paper pixels show paper/ink of 0 (black), never X.

## Structure
- Shared package zx_video_pkg holds:
  - H_OFF/V_OFF defaults;
  - ATTR_BASE = 13'h1800;
  - pix bit-field positions (bright=3, G=2, R=1, B=0).
- One sub-module, zx_scr_addr: combinational bitmap/attribute address from (sy, c, sel). It is reused by a future snapshot/DMA block.
- Everything else sits in a single module: phase logic, data latches, shifter, flash counter, sync delay.

## Test plan
- Reset: hold nRESET=0 while driving timing → pix=0, hs_out=vs_out=1, video_addr=0; release → outputs track inputs with 1-clk latency.
- Address order, MEM_LAT=2: y=V_OFF, x=H_OFF−16 → video_addr=0000 then 1800; cell 31 → 001F/181F; sy=1 → 0100/1800; sy=8 → 0020/1820; sy=191 → 17FF-line (last cell 17FF) and 1AFF.
- Pixel data: memory model returns bitmap 8'hA5, attr 8'h47 for cell 0 → first 16 columns: pix = F,F,8,8,F,F,8,8,8,8,F,F,8,8,F,F (bright, ink 7/paper 0 per bit).
- Flash: attr 8'h87, bitmap FF, 16 vs_in falling edges → pix changes from 7 to 0; after 32 edges → back to 7.
- Border/blank: border=3'b010 → pix=4'h2 at x=10 in a visible line; pix=0 with de_in=0; border change mid-line is visible next clk+1.
- Latency sweep: MEM_LAT=1 and 12 give identical pix streams to MEM_LAT=2 for a random frame buffer.
